// File: rtl/mcu_rst_pkg.sv
// rtl/mcu_rst_pkg.sv - shared state encodings and constants for the MCU reset sequencer
package mcu_rst_pkg;

    typedef enum logic [2:0] {
        ST_POR       = 3'd0,
        ST_PLL_RST   = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_STABLE    = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAIL      = 3'd5
    } seq_state_t;

    localparam int         CNT_W_DEF    = 26;
    localparam logic [7:0] LOSS_CNT_MAX = 8'hFF;

endpackage

// File: rtl/rst_sync_2ff.sv
// rtl/rst_sync_2ff.sv - two-flop synchroniser with asynchronous clear
module rst_sync_2ff (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mcu_reset_sequencer.sv
// rtl/mcu_reset_sequencer.sv - POR / PLL lock / CPU reset release sequencer
module mcu_reset_sequencer
    import mcu_rst_pkg::*;
#(
    parameter int POR_CYCLES     = 40000000,
    parameter int PLL_RST_CYCLES = 500,
    parameter int LOCK_TIMEOUT   = 5000000,
    parameter int LOCK_STABLE    = 1000,
    parameter int MAX_RETRY      = 3,
    parameter int CNT_W          = CNT_W_DEF
) (
    input  logic       CLK50M,
    input  logic       RSTN,
    input  logic       clk_cpu_i,
    input  logic       pll_lock_i,
    input  logic       soft_rst_req_i,
    output logic       pll_reset_o,
    output logic       cpu_reset_n_o,
    output logic [2:0] seq_state_o,
    output logic       lock_fail_o,
    output logic [7:0] lock_loss_cnt_o
);

    localparam int RETRY_W = $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0]   POR_LAST  = CNT_W'(POR_CYCLES - 1);
    localparam logic [CNT_W-1:0]   PLL_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TMO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STB_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    seq_state_t         state;
    logic [CNT_W-1:0]   cnt;
    logic [RETRY_W-1:0] retry;
    logic [RETRY_W-1:0] retry_inc;
    logic               lock_s;
    logic               soft_s;
    logic               soft_d;
    logic               soft_rise;
    logic               run_req;
    logic               cpu_sync_rstn;
    logic               cpu_rel;

    rst_sync_2ff u_lock_sync (.clk(CLK50M), .rstn(RSTN), .d(pll_lock_i),     .q(lock_s));
    rst_sync_2ff u_soft_sync (.clk(CLK50M), .rstn(RSTN), .d(soft_rst_req_i), .q(soft_s));

    assign soft_rise = soft_s & ~soft_d;
    assign retry_inc = retry + 1'b1;

    // The run request drops in the very cycle the synchronised lock loss or soft edge
    // appears, so the CPU reset asserts without waiting for the FSM to leave RUN.
    assign run_req       = (state == ST_RUN) & lock_s & ~soft_rise;
    assign cpu_sync_rstn = RSTN & run_req;

    rst_sync_2ff u_cpu_sync (.clk(clk_cpu_i), .rstn(cpu_sync_rstn), .d(1'b1), .q(cpu_rel));

    assign cpu_reset_n_o = RSTN & cpu_rel;
    assign seq_state_o   = state;

    always_ff @(posedge CLK50M or negedge RSTN) begin
        if (!RSTN) begin
            state           <= ST_POR;
            cnt             <= '0;
            retry           <= '0;
            soft_d          <= 1'b0;
            pll_reset_o     <= 1'b1;
            lock_fail_o     <= 1'b0;
            lock_loss_cnt_o <= '0;
        end else begin
            soft_d <= soft_s;
            case (state)
                ST_POR: begin
                    if (cnt == POR_LAST) begin
                        state <= ST_PLL_RST;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_PLL_RST: begin
                    if (cnt == PLL_LAST) begin
                        state       <= ST_WAIT_LOCK;
                        cnt         <= '0;
                        pll_reset_o <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state <= ST_STABLE;
                        cnt   <= '0;
                    end else if (cnt == TMO_LAST) begin
                        cnt         <= '0;
                        retry       <= retry_inc;
                        pll_reset_o <= 1'b1;
                        if (retry_inc == RETRY_MAX) begin
                            state       <= ST_FAIL;
                            lock_fail_o <= 1'b1;
                        end else begin
                            state <= ST_PLL_RST;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_STABLE: begin
                    // A single low sample restarts the wait; the retry budget is untouched.
                    if (!lock_s) begin
                        state <= ST_WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == STB_LAST) begin
                        state <= ST_RUN;
                        cnt   <= '0;
                        retry <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state       <= ST_PLL_RST;
                        pll_reset_o <= 1'b1;
                        if (lock_loss_cnt_o != LOSS_CNT_MAX) begin
                            lock_loss_cnt_o <= lock_loss_cnt_o + 1'b1;
                        end
                    end else if (soft_rise) begin
                        state       <= ST_PLL_RST;
                        pll_reset_o <= 1'b1;
                    end
                end
                ST_FAIL: begin
                    pll_reset_o <= 1'b1;
                end
                default: begin
                    state       <= ST_POR;
                    cnt         <= '0;
                    pll_reset_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mcu_reset_sequencer.sv
// tb/tb_mcu_reset_sequencer.sv - self-checking bench for mcu_reset_sequencer
module tb_mcu_reset_sequencer;

    localparam int POR    = 100;
    localparam int PLLR   = 10;
    localparam int TMO    = 200;
    localparam int STB    = 20;
    localparam int NRETRY = 3;
    localparam int W      = POR + PLLR;

    logic       CLK50M = 1'b0;
    logic       RSTN = 1'b0;
    logic       clk_cpu_i = 1'b0;
    logic       cpu_clk_en = 1'b0;
    logic       pll_lock_i = 1'b0;
    logic       soft_rst_req_i = 1'b0;
    logic       pll_reset_o;
    logic       cpu_reset_n_o;
    logic [2:0] seq_state_o;
    logic       lock_fail_o;
    logic [7:0] lock_loss_cnt_o;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [15:0] cyc;
        logic        lock;
        logic [2:0]  st;
        logic        pll;
        logic        cpun;
    } vec_t;

    vec_t tbl [0:9];

    mcu_reset_sequencer #(
        .POR_CYCLES(POR), .PLL_RST_CYCLES(PLLR), .LOCK_TIMEOUT(TMO),
        .LOCK_STABLE(STB), .MAX_RETRY(NRETRY), .CNT_W(16)
    ) dut (
        .CLK50M(CLK50M), .RSTN(RSTN), .clk_cpu_i(clk_cpu_i), .pll_lock_i(pll_lock_i),
        .soft_rst_req_i(soft_rst_req_i), .pll_reset_o(pll_reset_o), .cpu_reset_n_o(cpu_reset_n_o),
        .seq_state_o(seq_state_o), .lock_fail_o(lock_fail_o), .lock_loss_cnt_o(lock_loss_cnt_o)
    );

    always #10 CLK50M = ~CLK50M;
    always #7 clk_cpu_i = cpu_clk_en ? ~clk_cpu_i : 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK50M);
        RSTN = 1'b0; pll_lock_i = 1'b0; soft_rst_req_i = 1'b0;
        repeat (2) @(negedge CLK50M);
        RSTN = 1'b1;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLK50M);
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string name);
        int k;
        k = 0;
        while (seq_state_o !== s && k < budget) begin
            @(negedge CLK50M);
            k++;
        end
        check({name, " reach state"}, seq_state_o, s);
    endtask

    task automatic async_rst_check(input string name);
        @(posedge CLK50M);
        #3 RSTN = 1'b0;
        #1;
        check({name, " state"}, seq_state_o, 0);
        check({name, " pll_reset"}, pll_reset_o, 1);
        check({name, " cpu_reset_n"}, cpu_reset_n_o, 0);
        check({name, " lock_fail"}, lock_fail_o, 0);
        check({name, " loss_cnt"}, lock_loss_cnt_o, 0);
    endtask

    // Lock as driven by the bench after sample k: rises at t, optional one-cycle dropout at t+g.
    function automatic logic lock_drv(input int k, input int t, input int g, input bit gl);
        return (k >= t) && !(gl && k == t + g);
    endfunction

    // RUN begins on the first sample preceded by STB+1 consecutive synchronised-high lock
    // samples (two-flop delay), the earliest of which lies inside the lock-wait window.
    function automatic int exp_run(input int t, input int g, input bit gl);
        bit ok;
        for (int r = W + STB + 1; r < 3000; r++) begin
            ok = 1'b1;
            for (int x = r - STB - 1; x <= r - 1; x++)
                if (x < 2 || !lock_drv(x - 2, t, g, gl)) ok = 1'b0;
            if (ok) return r;
        end
        return -1;
    endfunction

    function automatic logic exp_pll_tmo(input int k);
        logic v;
        v = (k < W) || (k >= POR + NRETRY * (PLLR + TMO));
        for (int i = 1; i < NRETRY; i++)
            if (k >= POR + i * (PLLR + TMO) && k < POR + i * (PLLR + TMO) + PLLR) v = 1'b1;
        return v;
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx, npll, t, g, er, got;
        bit gl;
        logic lk;
        int fail_at;

        tbl[0] = {16'd0,   1'b0, 3'd0, 1'b1, 1'b0};
        tbl[1] = {16'd99,  1'b0, 3'd0, 1'b1, 1'b0};
        tbl[2] = {16'd100, 1'b0, 3'd1, 1'b1, 1'b0};
        tbl[3] = {16'd109, 1'b0, 3'd1, 1'b1, 1'b0};
        tbl[4] = {16'd110, 1'b0, 3'd2, 1'b0, 1'b0};
        tbl[5] = {16'd160, 1'b1, 3'd2, 1'b0, 1'b0};
        tbl[6] = {16'd162, 1'b1, 3'd2, 1'b0, 1'b0};
        tbl[7] = {16'd163, 1'b1, 3'd3, 1'b0, 1'b0};
        tbl[8] = {16'd182, 1'b1, 3'd3, 1'b0, 1'b0};
        tbl[9] = {16'd183, 1'b1, 3'd4, 1'b0, 1'b0};

        // Nominal sequence with the CPU clock stopped
        do_reset();
        idx = 0; npll = 0;
        for (int k = 0; k <= 185; k++) begin
            if (pll_reset_o === 1'b1) npll++;
            if (idx < 10 && int'(tbl[idx].cyc) == k) begin
                check($sformatf("nom c%0d state", k), seq_state_o, tbl[idx].st);
                check($sformatf("nom c%0d pll_reset", k), pll_reset_o, tbl[idx].pll);
                check($sformatf("nom c%0d cpu_reset_n", k), cpu_reset_n_o, tbl[idx].cpun);
                pll_lock_i = tbl[idx].lock;
                idx++;
            end
            @(negedge CLK50M);
        end
        check("nom pll_reset high cycles", npll, W);
        check("nom cpu held with clock stopped", cpu_reset_n_o, 0);
        cpu_clk_en = 1'b1;
        @(posedge clk_cpu_i); #1;
        check("nom cpu_reset_n after 1 cpu edge", cpu_reset_n_o, 0);
        @(posedge clk_cpu_i); #1;
        check("nom cpu_reset_n after 2 cpu edges", cpu_reset_n_o, 1);
        cpu_clk_en = 1'b0;

        // Lock arrival / glitch trials against the window model; trial 0 is the fixed glitch case
        for (int tr = 0; tr < 12; tr++) begin
            t  = (tr == 0) ? 160 : int'($urandom_range(50, 280));
            gl = (tr == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            g  = (tr == 0) ? 15 : int'($urandom_range(1, 25));
            er = exp_run(t, g, gl);
            got = -1;
            do_reset();
            for (int k = 0; k <= er + 3; k++) begin
                if (got < 0 && seq_state_o === 3'd4) got = k;
                pll_lock_i = lock_drv(k, t, g, gl);
                @(negedge CLK50M);
            end
            check($sformatf("trial%0d t=%0d g=%0d gl=%0d run cycle", tr, t, g, gl), got, er);
            check($sformatf("trial%0d lock_fail", tr), lock_fail_o, 0);
        end

        // Timeout and retry exhaustion, CPU clock running
        cpu_clk_en = 1'b1;
        do_reset();
        fail_at = POR + NRETRY * (PLLR + TMO);
        for (int k = 0; k <= fail_at + 10; k++) begin
            check($sformatf("tmo c%0d pll_reset", k), pll_reset_o, exp_pll_tmo(k));
            check($sformatf("tmo c%0d lock_fail", k), lock_fail_o, k >= fail_at);
            @(negedge CLK50M);
        end
        check("tmo state", seq_state_o, 5);
        check("tmo cpu_reset_n", cpu_reset_n_o, 0);
        soft_rst_req_i = 1'b1;
        step(20);
        check("fail ignores soft state", seq_state_o, 5);
        check("fail ignores soft lock_fail", lock_fail_o, 1);
        do_reset();
        check("recover state", seq_state_o, 0);
        check("recover lock_fail", lock_fail_o, 0);

        // Lock loss in RUN, repeated until the counter saturates
        pll_lock_i = 1'b1;
        wait_state(3'd4, 300, "loss init");
        for (int i = 0; i < 260; i++) begin
            step(5);
            check($sformatf("loss%0d cpu released", i), cpu_reset_n_o, 1);
            pll_lock_i = 1'b0;
            step(2);
            check($sformatf("loss%0d cpu_reset_n at sync drop", i), cpu_reset_n_o, 0);
            step(1);
            check($sformatf("loss%0d state", i), seq_state_o, 1);
            check($sformatf("loss%0d count", i), lock_loss_cnt_o, (i + 1 > 255) ? 255 : i + 1);
            pll_lock_i = 1'b1;
            wait_state(3'd4, 100, $sformatf("loss%0d relock", i));
        end

        // Simultaneous lock loss and soft request, then soft request alone
        do_reset();
        pll_lock_i = 1'b1;
        wait_state(3'd4, 300, "sim init");
        step(5);
        pll_lock_i = 1'b0; soft_rst_req_i = 1'b1;
        step(3);
        check("sim state", seq_state_o, 1);
        check("sim count", lock_loss_cnt_o, 1);
        pll_lock_i = 1'b1;
        step(5);
        soft_rst_req_i = 1'b0;
        wait_state(3'd4, 100, "sim relock");
        step(30);
        check("sim single resequence state", seq_state_o, 4);
        check("sim single resequence count", lock_loss_cnt_o, 1);
        soft_rst_req_i = 1'b1;
        step(2);
        check("soft cpu_reset_n", cpu_reset_n_o, 0);
        step(1);
        check("soft state", seq_state_o, 1);
        check("soft count unchanged", lock_loss_cnt_o, 1);
        soft_rst_req_i = 1'b0;
        wait_state(3'd4, 100, "soft relock");
        step(5);
        check("run cpu released", cpu_reset_n_o, 1);

        // Asynchronous reset mid-RUN with the CPU clock stopped, then mid-STABLE
        cpu_clk_en = 1'b0;
        async_rst_check("rstn mid-run");
        do_reset();
        pll_lock_i = 1'b1;
        wait_state(3'd3, 300, "stable init");
        step(5);
        async_rst_check("rstn mid-stable");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mcu_reset_sequencer.md
Name: mcu_reset_sequencer

Overview:
Power-on and clock-domain reset sequencer for the MCU top level, clocked by CLK50M. It replaces the ad-hoc POR counter: it holds off the PLL and pulses its reset, waits for a stable lock (with timeout and retry), and only then releases the CPU reset. The CPU reset is asserted asynchronously and released synchronously to the PLL-generated CPU clock. Lock loss and software reset requests re-run the sequence.

Parameters:
POR_CYCLES, 40000000, CLK50M cycles spent in POR after RSTN deassertion (sims use small values)
PLL_RST_CYCLES, 500, width of the pll_reset_o pulse in CLK50M cycles
LOCK_TIMEOUT, 5000000, max cycles in WAIT_LOCK before a retry (100 ms)
LOCK_STABLE, 1000, consecutive cycles the synchronised lock must stay high before release
MAX_RETRY, 3, PLL reset attempts before entering FAIL
CNT_W, 26, width of the shared phase counter; must hold max(POR_CYCLES, LOCK_TIMEOUT)

Ports:
CLK50M  input  1  free-running 50 MHz reference clock
RSTN  input  1  asynchronous active-low board reset
clk_cpu_i  input  1  PLL output clock (CPU domain)
pll_lock_i  input  1  PLL lock, asynchronous to CLK50M
soft_rst_req_i  input  1  level request to re-sequence, asynchronous (from an APB register)
pll_reset_o  output  1  active-high PLL reset
cpu_reset_n_o  output  1  active-low CPU reset, synchronous deassertion in clk_cpu_i domain
seq_state_o  output  3  current FSM state encoding
lock_fail_o  output  1  sticky: retries exhausted
lock_loss_cnt_o  output  8  saturating count of lock losses while in RUN

Behaviour:
- Reset (RSTN low, async): state=POR, counter=0, retry=0, pll_reset_o=1, cpu_reset_n_o=0, lock_fail_o=0, lock_loss_cnt_o=0.
- pll_lock_i and soft_rst_req_i pass through 2-flop synchronisers on CLK50M (2-cycle latency); soft request acts on its synchronised rising edge.
- State encodings: POR=0, PLL_RST=1, WAIT_LOCK=2, STABLE=3, RUN=4, FAIL=5.
- POR: pll_reset_o=1; count to POR_CYCLES-1, then PLL_RST with counter cleared.
- PLL_RST: pll_reset_o=1 for exactly PLL_RST_CYCLES cycles, then WAIT_LOCK. pll_reset_o is 0 in every other state except POR and FAIL.
- WAIT_LOCK: lock_s=1 -> STABLE, counter=0. Counter reaching LOCK_TIMEOUT-1 without lock: retry+1. If new retry==MAX_RETRY -> FAIL, else -> PLL_RST.
- STABLE: counter increments while lock_s=1. Any lock_s=0 -> back to WAIT_LOCK, counter cleared, timeout restarts, retry unchanged. Counter==LOCK_STABLE-1 -> RUN, retry cleared.
- RUN: cpu_run request=1. lock_s falling -> request=0 the same cycle, lock_loss_cnt_o+1 (saturating at 255), then PLL_RST. Soft request edge -> request=0, then PLL_RST; lock_loss_cnt_o unchanged.
- FAIL: pll_reset_o=1, cpu request=0, lock_fail_o=1. Held until RSTN; soft requests are ignored.
- CPU reset: cpu_reset_n_o = AND of RSTN and a 2-flop clk_cpu_i synchroniser fed by the run request. Both flops clear asynchronously when RSTN=0 or the run request=0.
  - Assertion is therefore asynchronous and immediate.
  - Deassertion occurs 2 clk_cpu_i edges after entering RUN.
  - If clk_cpu_i is stopped, cpu_reset_n_o stays 0.
- Simultaneous events in RUN: lock loss has priority over a soft request; the count increments once.
- Counter is CNT_W bits and is cleared on every state transition. It never wraps because every terminal value < 2^CNT_W.

Decomposition:
- Package mcu_rst_pkg holds the state encodings, the CNT_W default and the lock_loss_cnt saturation constant.
- One sub-module, rst_sync_2ff: async-assert/sync-deassert synchroniser, used for cpu_reset_n_o.
- The plain 2-flop level synchronisers are reused for lock and soft_rst.

Test Plan:
- Nominal: POR_CYCLES=100, PLL_RST_CYCLES=10, LOCK_STABLE=20; lock rises 50 cycles after PLL_RST ends -> pll_reset_o high for cycles 0-109, RUN reached after lock+2+20 cycles, cpu_reset_n_o rises 2 clk_cpu edges later, seq_state_o=4.
- Timeout/retry: LOCK_TIMEOUT=200, MAX_RETRY=3, lock never rises -> three 10-cycle pll_reset_o pulses 200 cycles apart, then state=5, lock_fail_o=1, cpu_reset_n_o stays 0. A soft request is then ignored; RSTN pulse recovers.
- Glitchy lock: lock toggles high 15 cycles, low 1, high again -> STABLE aborts to WAIT_LOCK, RUN reached only after 20 continuous cycles, retry count unchanged.
- Lock loss in RUN: drop lock -> cpu_reset_n_o falls within the same CLK50M cycle as the synchronised drop, lock_loss_cnt_o=1, PLL_RST pulse follows. Repeat 260 times -> counter saturates at 255.
- Soft request in the same cycle as lock loss -> single re-sequence, lock_loss_cnt_o increments by exactly 1. Soft request alone -> re-sequence, count unchanged.
- RSTN asserted mid-STABLE and mid-RUN -> all outputs return to reset values asynchronously, including cpu_reset_n_o with clk_cpu_i stopped.
